// File: rtl/mem_bus_master_if.sv
// Bus bundle between the request sequencer, its two clients and the startup RAM.
// The master modport is the sequencer's view; slave is the environment's view.
interface mem_bus_master_if #(
   parameter int unsigned ADDR_SIZE0 = 15,
   parameter int unsigned DATA_SIZE0 = 7
);
   // Client A (instruction fetch) and client B (data)
   logic                a_rd_q;
   logic                a_wr_q;
   logic [ADDR_SIZE0:0] a_addr;
   logic [DATA_SIZE0:0] a_wdata;
   logic [DATA_SIZE0:0] a_rdata;
   logic                a_dn;
   logic                a_err;
   logic                b_rd_q;
   logic                b_wr_q;
   logic [ADDR_SIZE0:0] b_addr;
   logic [DATA_SIZE0:0] b_wdata;
   logic [DATA_SIZE0:0] b_rdata;
   logic                b_dn;
   logic                b_err;
   // RAM side
   logic                read_q;
   logic                write_q;
   logic [ADDR_SIZE0:0] addr_out;
   logic [DATA_SIZE0:0] data_out;
   logic                read_dn;
   logic                write_dn;
   logic [ADDR_SIZE0:0] addr_in;
   logic [DATA_SIZE0:0] data_in;
   logic                rw_halt;
   logic                busy;

   modport master (
      input  a_rd_q, a_wr_q, a_addr, a_wdata,
      input  b_rd_q, b_wr_q, b_addr, b_wdata,
      output a_rdata, a_dn, a_err, b_rdata, b_dn, b_err,
      output read_q, write_q, addr_out, data_out, rw_halt, busy,
      input  read_dn, write_dn, addr_in, data_in
   );

   modport slave (
      output a_rd_q, a_wr_q, a_addr, a_wdata,
      output b_rd_q, b_wr_q, b_addr, b_wdata,
      input  a_rdata, a_dn, a_err, b_rdata, b_dn, b_err,
      input  read_q, write_q, addr_out, data_out, rw_halt, busy,
      output read_dn, write_dn, addr_in, data_in
   );
endinterface

// File: rtl/mem_bus_master.sv
// Two-client request sequencer in front of the startup RAM. Round-robin grant, one-cycle
// RAM request pulse, wait for the matching done strobe, and a timeout that aborts accesses
// the RAM silently drops (out-of-range addresses) via rw_halt.
module mem_bus_master #(
   parameter int unsigned ADDR_SIZE0 = 15,
   parameter int unsigned DATA_SIZE0 = 7,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_oe,
   mem_bus_master_if.master bus
);
   localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

   typedef enum logic [2:0] {StIdle, StIssue, StWaitDn, StResp, StHalt} state_e;

   state_e              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                last_q, last_d;     // previous winner: 0 = A, 1 = B
   logic                id_q, id_d;         // current client: 0 = A, 1 = B
   logic                wr_q, wr_d;         // current op is a write
   logic [ADDR_SIZE0:0] addr_q, addr_d;
   logic [DATA_SIZE0:0] dout_q, dout_d;
   logic [DATA_SIZE0:0] cap_q, cap_d;      // data captured with the done strobe
   logic [DATA_SIZE0:0] a_rdata_q, a_rdata_d;
   logic [DATA_SIZE0:0] b_rdata_q, b_rdata_d;
   logic                rd_req_q, rd_req_d;
   logic                wr_req_q, wr_req_d;
   logic                a_dn_q, a_dn_d;
   logic                b_dn_q, b_dn_d;
   logic                a_err_q, a_err_d;
   logic                b_err_q, b_err_d;
   logic                halt_q, halt_d;

   logic a_req, b_req, grant_b, strobe_ok;

   assign a_req   = bus.a_rd_q | bus.a_wr_q;
   assign b_req   = bus.b_rd_q | bus.b_wr_q;
   // B wins when it is alone, or on a tie when A won last time
   assign grant_b = b_req & (~a_req | ~last_q);
   assign strobe_ok = ((~wr_q & bus.read_dn) | (wr_q & bus.write_dn)) & (bus.addr_in == addr_q);

   // Next-state and registered-output logic; pulses default low, everything else holds
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      id_d      = id_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      dout_d    = dout_q;
      cap_d     = cap_q;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      rd_req_d  = 1'b0;
      wr_req_d  = 1'b0;
      a_dn_d    = 1'b0;
      b_dn_d    = 1'b0;
      a_err_d   = 1'b0;
      b_err_d   = 1'b0;
      halt_d    = 1'b0;
      case (state_q)
         StIdle: begin
            if (a_req || b_req) begin
               id_d = grant_b;
               if (grant_b) begin
                  wr_d   = ~bus.b_rd_q;
                  addr_d = bus.b_addr;
                  dout_d = bus.b_rd_q ? '0 : bus.b_wdata;
               end else begin
                  wr_d   = ~bus.a_rd_q;
                  addr_d = bus.a_addr;
                  dout_d = bus.a_rd_q ? '0 : bus.a_wdata;
               end
               state_d = StIssue;
            end
         end
         StIssue: begin
            rd_req_d = ~wr_q;
            wr_req_d = wr_q;
            cnt_d    = '0;
            state_d  = StWaitDn;
         end
         StWaitDn: begin
            if (strobe_ok) begin
               cap_d   = bus.data_in;
               state_d = StResp;
            end else if (cnt_q == TimeoutCnt) begin
               a_err_d = ~id_q;
               b_err_d = id_q;
               state_d = StHalt;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StResp: begin
            a_dn_d = ~id_q;
            b_dn_d = id_q;
            if (!wr_q) begin
               if (id_q) b_rdata_d = cap_q;
               else      a_rdata_d = cap_q;
            end
            last_d  = id_q;
            state_d = StIdle;
         end
         StHalt: begin
            halt_d  = 1'b1;
            last_d  = id_q;
            addr_d  = '0;
            dout_d  = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State register; advances only on phase-enabled edges
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         last_q    <= 1'b1;
         id_q      <= 1'b0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         dout_q    <= '0;
         cap_q     <= '0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
         rd_req_q  <= 1'b0;
         wr_req_q  <= 1'b0;
         a_dn_q    <= 1'b0;
         b_dn_q    <= 1'b0;
         a_err_q   <= 1'b0;
         b_err_q   <= 1'b0;
         halt_q    <= 1'b0;
      end else if (clk_oe) begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         id_q      <= id_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         dout_q    <= dout_d;
         cap_q     <= cap_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
         rd_req_q  <= rd_req_d;
         wr_req_q  <= wr_req_d;
         a_dn_q    <= a_dn_d;
         b_dn_q    <= b_dn_d;
         a_err_q   <= a_err_d;
         b_err_q   <= b_err_d;
         halt_q    <= halt_d;
      end
   end

   assign bus.a_rdata  = a_rdata_q;
   assign bus.b_rdata  = b_rdata_q;
   assign bus.a_dn     = a_dn_q;
   assign bus.b_dn     = b_dn_q;
   assign bus.a_err    = a_err_q;
   assign bus.b_err    = b_err_q;
   assign bus.read_q   = rd_req_q;
   assign bus.write_q  = wr_req_q;
   assign bus.addr_out = addr_q;
   assign bus.data_out = dout_q;
   assign bus.rw_halt  = halt_q;
   assign bus.busy     = (state_q != StIdle);
endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: RAM model, two client drivers, per-port scoreboards.
module tb_mem_bus_master;
   localparam int unsigned AW0 = 15;
   localparam int unsigned DW0 = 7;
   localparam int Timeout = 16;

   typedef struct {
      bit port; bit wr; logic [15:0] addr; logic [7:0] wdata; bit err; logic [7:0] data;
   } vec_t;
   typedef struct { bit wr; logic [15:0] addr; logic [7:0] wdata; } req_t;
   typedef struct { bit rd; bit err; logic [7:0] data; bit chk_lat; } exp_t;

   logic clk = 1'b0, rst = 1'b0, clk_oe = 1'b1;
   bit   oe_toggle = 1'b0;
   int   n_vec = 0, n_err = 0;

   mem_bus_master_if #(.ADDR_SIZE0(AW0), .DATA_SIZE0(DW0)) bus ();
   mem_bus_master #(.ADDR_SIZE0(AW0), .DATA_SIZE0(DW0), .TIMEOUT(Timeout)) dut (
      .clk(clk), .rst(rst), .clk_oe(clk_oe), .bus(bus)
   );

   always #5 clk = ~clk;
   always @(negedge clk) clk_oe = oe_toggle ? ~clk_oe : 1'b1;

   // RAM model: 256 words, out-of-range addresses ignored, strobe two active edges after request
   logic [7:0]  mem [256];
   int          ram_st = 0;
   logic [15:0] ram_a, ram_addr = '0;
   logic [7:0]  ram_wd, ram_data = '0;
   logic        ram_rd_dn = 1'b0, ram_wr_dn = 1'b0;
   bit          ram_mute = 1'b0;
   logic        inj_rd_dn = 1'b0;
   logic [15:0] inj_addr = '0;
   logic [7:0]  inj_data = '0;

   assign bus.read_dn  = ram_rd_dn | inj_rd_dn;
   assign bus.write_dn = ram_wr_dn;
   assign bus.addr_in  = inj_rd_dn ? inj_addr : ram_addr;
   assign bus.data_in  = inj_rd_dn ? inj_data : ram_data;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         ram_st <= 0; ram_rd_dn <= 1'b0; ram_wr_dn <= 1'b0;
      end else if (clk_oe) begin
         ram_rd_dn <= 1'b0;
         ram_wr_dn <= 1'b0;
         if (ram_st == 1) begin
            ram_rd_dn <= 1'b1; ram_addr <= ram_a; ram_data <= mem[ram_a[7:0]]; ram_st <= 0;
         end else if (ram_st == 2) begin
            ram_wr_dn <= 1'b1; ram_addr <= ram_a; mem[ram_a[7:0]] = ram_wd; ram_st <= 0;
         end else if (!ram_mute && bus.addr_out < 16'd256) begin
            if (bus.read_q) begin
               ram_st <= 1; ram_a <= bus.addr_out;
            end else if (bus.write_q) begin
               ram_st <= 2; ram_a <= bus.addr_out; ram_wd <= bus.data_out;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   req_t cq_a[$], cq_b[$];
   exp_t sb_a[$], sb_b[$];
   bit   comp_log[$];
   bit   a_act = 1'b0, b_act = 1'b0;
   int   act_cnt = 0, clk_cnt = 0, grant_edge = 0, grant_clk = 0, lat_clk = 0, err_edge = 0;
   int   rq_cnt = 0, wq_cnt = 0, halt_cnt = 0;
   logic [6:0] pulses, prev_pulses = '0;
   logic [7:0] hold_prev = '0;
   bit   prev_busy = 1'b0;

   task automatic issue(input bit port, input bit wr, input logic [15:0] addr,
                        input logic [7:0] wdata, input bit err, input logic [7:0] data,
                        input bit chk_lat);
      req_t r;
      exp_t e;
      r = '{wr: wr, addr: addr, wdata: wdata};
      e = '{rd: !wr, err: err, data: data, chk_lat: chk_lat};
      if (port) begin cq_b.push_back(r); sb_b.push_back(e); end
      else      begin cq_a.push_back(r); sb_a.push_back(e); end
   endtask

   task automatic complete(input bit port, input logic dn, input logic er,
                           input logic [7:0] rd);
      exp_t e;
      check("dn/err exclusive", 32'(dn & er), 0);
      if ((port ? sb_b.size() : sb_a.size()) == 0) begin
         n_vec++; n_err++;
         $display("FAIL unexpected completion on port %0d: dn=%0b err=%0b, expected none",
                  port, dn, er);
      end else begin
         e = port ? sb_b.pop_front() : sb_a.pop_front();
         check("err flag", 32'(er), 32'(e.err));
         if (e.err) begin
            check("err latency", act_cnt - grant_edge, Timeout + 2);
            err_edge = act_cnt;
         end else begin
            if (e.rd) check(port ? "b_rdata" : "a_rdata", rd, e.data);
            if (e.chk_lat) check("dn latency", act_cnt - grant_edge, 5);
         end
      end
      lat_clk = clk_cnt - grant_clk;
      comp_log.push_back(port);
      if (port) begin b_act = 1'b0; bus.b_rd_q = 1'b0; bus.b_wr_q = 1'b0; end
      else      begin a_act = 1'b0; bus.a_rd_q = 1'b0; bus.a_wr_q = 1'b0; end
   endtask

   // Monitor and client drivers: sample 1 time unit after each edge
   always @(posedge clk) begin : mon
      bit   oe_s;
      req_t r;
      oe_s = clk_oe;
      #1;
      clk_cnt++;
      pulses = {bus.a_dn, bus.b_dn, bus.a_err, bus.b_err, bus.read_q, bus.write_q, bus.rw_halt};
      if (!rst) begin
         a_act = 1'b0; b_act = 1'b0;
         bus.a_rd_q = 1'b0; bus.a_wr_q = 1'b0; bus.b_rd_q = 1'b0; bus.b_wr_q = 1'b0;
         bus.a_addr = '0; bus.b_addr = '0; bus.a_wdata = '0; bus.b_wdata = '0;
         prev_pulses = '0; prev_busy = 1'b0;
      end else if (!oe_s) begin
         check("hold on inactive edge", {pulses, bus.busy}, hold_prev);
      end else begin
         act_cnt++;
         if (prev_pulses != '0) check("pulse width", pulses & prev_pulses, 0);
         if (bus.read_q) begin rq_cnt++; check("data_out on read", bus.data_out, 0); end
         if (bus.write_q) wq_cnt++;
         if (bus.busy && !prev_busy) begin grant_edge = act_cnt; grant_clk = clk_cnt; end
         if (bus.rw_halt) begin halt_cnt++; check("rw_halt latency", act_cnt - err_edge, 1); end
         if (bus.a_dn || bus.a_err) complete(1'b0, bus.a_dn, bus.a_err, bus.a_rdata);
         if (bus.b_dn || bus.b_err) complete(1'b1, bus.b_dn, bus.b_err, bus.b_rdata);
         prev_busy = bus.busy;
         prev_pulses = pulses;
         if (!a_act && cq_a.size() > 0) begin
            r = cq_a.pop_front();
            bus.a_rd_q = !r.wr; bus.a_wr_q = r.wr; bus.a_addr = r.addr; bus.a_wdata = r.wdata;
            a_act = 1'b1;
         end
         if (!b_act && cq_b.size() > 0) begin
            r = cq_b.pop_front();
            bus.b_rd_q = !r.wr; bus.b_wr_q = r.wr; bus.b_addr = r.addr; bus.b_wdata = r.wdata;
            b_act = 1'b1;
         end
      end
      hold_prev = {pulses, bus.busy};
   end

   task automatic wait_idle(input int max_cyc);
      int k;
      for (k = 0; k < max_cyc; k++) begin
         @(negedge clk);
         if (cq_a.size() == 0 && cq_b.size() == 0 && sb_a.size() == 0 && sb_b.size() == 0 &&
             !a_act && !b_act && !bus.busy) break;
      end
      if (k == max_cyc) begin
         n_vec++; n_err++;
         $display("FAIL wait_idle: still busy after %0d cycles, expected idle", max_cyc);
      end
   endtask

   task automatic wait_read_q(input int rq0);
      for (int k = 0; k < 60 && rq_cnt == rq0; k++) @(negedge clk);
      check("read_q issued", 32'(rq_cnt != rq0), 1);
   endtask

   initial begin : main
      vec_t tbl[10];
      int rq0, wq0, h0;
      logic [7:0] rd_before;
      tbl[0] = '{port: 0, wr: 0, addr: 16'h0011, wdata: 8'h00, err: 0, data: 8'h10};
      tbl[1] = '{port: 0, wr: 1, addr: 16'h0003, wdata: 8'h5A, err: 0, data: 8'h00};
      tbl[2] = '{port: 0, wr: 0, addr: 16'h0003, wdata: 8'h00, err: 0, data: 8'h5A};
      tbl[3] = '{port: 1, wr: 0, addr: 16'h0020, wdata: 8'h00, err: 0, data: 8'h1F};
      tbl[4] = '{port: 1, wr: 1, addr: 16'h0040, wdata: 8'hC3, err: 0, data: 8'h00};
      tbl[5] = '{port: 1, wr: 0, addr: 16'h0040, wdata: 8'h00, err: 0, data: 8'hC3};
      tbl[6] = '{port: 0, wr: 0, addr: 16'h00FF, wdata: 8'h00, err: 0, data: 8'hFE};
      tbl[7] = '{port: 1, wr: 0, addr: 16'hFFFF, wdata: 8'h00, err: 1, data: 8'h00};
      tbl[8] = '{port: 0, wr: 0, addr: 16'h0011, wdata: 8'h00, err: 0, data: 8'h10};
      tbl[9] = '{port: 1, wr: 0, addr: 16'h0021, wdata: 8'h00, err: 0, data: 8'h20};
      for (int i = 0; i < 256; i++) mem[i] = 8'(i - 1);

      repeat (3) @(negedge clk);
      check("reset pulses/busy", {bus.a_dn, bus.b_dn, bus.a_err, bus.b_err, bus.read_q,
                                  bus.write_q, bus.rw_halt, bus.busy}, 0);
      check("reset rdata", {bus.a_rdata, bus.b_rdata}, 0);
      check("reset addr/data out", {bus.addr_out, bus.data_out}, 0);
      rst = 1'b1;
      @(negedge clk);

      // Single transactions, one at a time
      for (int i = 0; i < 10; i++) begin
         rq0 = rq_cnt; wq0 = wq_cnt; h0 = halt_cnt;
         rd_before = tbl[i].port ? bus.b_rdata : bus.a_rdata;
         issue(tbl[i].port, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].err, tbl[i].data, 1'b1);
         wait_idle(300);
         check($sformatf("v%0d read_q count", i), rq_cnt - rq0, tbl[i].wr ? 0 : 1);
         check($sformatf("v%0d write_q count", i), wq_cnt - wq0, tbl[i].wr ? 1 : 0);
         check($sformatf("v%0d rw_halt count", i), halt_cnt - h0, tbl[i].err ? 1 : 0);
         if (tbl[i].err) check($sformatf("v%0d addr_out cleared", i), bus.addr_out, 0);
         else if (tbl[i].wr)
            check($sformatf("v%0d rdata held", i), tbl[i].port ? bus.b_rdata : bus.a_rdata,
                  rd_before);
         else
            check($sformatf("v%0d rdata after", i), tbl[i].port ? bus.b_rdata : bus.a_rdata,
                  tbl[i].data);
      end

      // Both clients contend with two reads each: expect A, B, A, B
      comp_log.delete();
      issue(1'b0, 1'b0, 16'h0001, 8'h00, 1'b0, 8'h00, 1'b1);
      issue(1'b0, 1'b0, 16'h0001, 8'h00, 1'b0, 8'h00, 1'b1);
      issue(1'b1, 1'b0, 16'h0002, 8'h00, 1'b0, 8'h01, 1'b1);
      issue(1'b1, 1'b0, 16'h0002, 8'h00, 1'b0, 8'h01, 1'b1);
      wait_idle(300);
      check("round-robin count", comp_log.size(), 4);
      if (comp_log.size() == 4)
         check("round-robin order", {comp_log[0], comp_log[1], comp_log[2], comp_log[3]},
               4'b0101);

      // Stray strobe with wrong address, then the real one
      ram_mute = 1'b1;
      rq0 = rq_cnt;
      issue(1'b0, 1'b0, 16'h0030, 8'h00, 1'b0, 8'h77, 1'b0);
      wait_read_q(rq0);
      repeat (2) @(negedge clk);
      inj_addr = 16'h0031; inj_data = 8'hEE; inj_rd_dn = 1'b1;
      @(negedge clk);
      inj_rd_dn = 1'b0;
      repeat (3) @(negedge clk);
      check("stray strobe: still busy", bus.busy, 1);
      check("stray strobe: no completion", sb_a.size(), 1);
      inj_addr = 16'h0030; inj_data = 8'h77; inj_rd_dn = 1'b1;
      @(negedge clk);
      inj_rd_dn = 1'b0;
      wait_idle(100);
      ram_mute = 1'b0;
      check("stray strobe: a_rdata", bus.a_rdata, 8'h77);

      // Phase enable toggling: same active-edge latency, double in clock edges
      oe_toggle = 1'b1;
      issue(1'b0, 1'b0, 16'h0011, 8'h00, 1'b0, 8'h10, 1'b1);
      wait_idle(300);
      check("clk_oe latency in clk edges", lat_clk, 10);
      oe_toggle = 1'b0;
      repeat (2) @(negedge clk);

      // Asynchronous reset in WAIT_DN drops the transaction
      ram_mute = 1'b1;
      rq0 = rq_cnt;
      cq_a.push_back('{wr: 1'b0, addr: 16'h0050, wdata: 8'h00});
      wait_read_q(rq0);
      repeat (2) @(negedge clk);
      check("busy before mid reset", bus.busy, 1);
      #2 rst = 1'b0;
      #1;
      check("mid reset pulses/busy", {bus.a_dn, bus.b_dn, bus.a_err, bus.b_err, bus.read_q,
                                      bus.write_q, bus.rw_halt, bus.busy}, 0);
      check("mid reset rdata", {bus.a_rdata, bus.b_rdata}, 0);
      check("mid reset addr/data out", {bus.addr_out, bus.data_out}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      ram_mute = 1'b0;
      repeat (25) @(negedge clk);
      check("after reset: idle", bus.busy, 0);

      // After reset A wins the first tie again
      comp_log.delete();
      issue(1'b1, 1'b0, 16'h0021, 8'h00, 1'b0, 8'h20, 1'b1);
      issue(1'b0, 1'b0, 16'h0011, 8'h00, 1'b0, 8'h10, 1'b1);
      wait_idle(300);
      check("post-reset tie count", comp_log.size(), 2);
      if (comp_log.size() == 2) check("post-reset tie order", {comp_log[0], comp_log[1]}, 2'b01);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Two-port request sequencer that sits directly upstream of the internal startup RAM. It arbitrates between an instruction-fetch client (port A) and a data client (port B), and issues one-cycle read/write request pulses on the RAM bus. It then waits for the matching done strobe and returns the data or an error to the winning client. A per-transaction timeout handles out-of-range addresses: the RAM silently ignores those, and the timeout aborts the access through `rw_halt`.

## Interface
- `TIMEOUT`, 16: active (clk_oe=1) cycles to wait for a done strobe before erroring; legal range 2..255.
- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `clk_oe`  in  1  phase enable; FSM, counter and arbiter advance only on edges where `clk_oe`=1; all outputs hold otherwise.
- `a_rd_q` / `b_rd_q`  in  1  client read request, level, held until `x_dn` or `x_err`.
- `a_wr_q` / `b_wr_q`  in  1  client write request, same rule; if both rd and wr are high, read wins.
- `a_addr` / `b_addr`  in  `ADDR_SIZE0+1`  client address, sampled at grant.
- `a_wdata` / `b_wdata`  in  `DATA_SIZE0+1`  client write data, sampled at grant.
- `a_rdata` / `b_rdata`  out  `DATA_SIZE0+1`  read data; valid while `x_dn`=1; otherwise holds its last value.
- `a_dn` / `b_dn`  out  1  one-active-cycle completion pulse.
- `a_err` / `b_err`  out  1  one-active-cycle timeout pulse (mutually exclusive with `x_dn`).
- `read_q`, `write_q`  out  1  RAM request pulses.
- `addr_out`  out  `ADDR_SIZE0+1`  RAM address.
- `data_out`  out  `DATA_SIZE0+1`  RAM write data.
- `read_dn`, `write_dn`  in  1  RAM done strobes.
- `addr_in`  in  `ADDR_SIZE0+1`  address echoed by the RAM with its done strobe.
- `data_in`  in  `DATA_SIZE0+1`  data returned by the RAM with its done strobe.
- `rw_halt`  out  1  RAM abort, one-active-cycle pulse.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT_DN, RESP, HALT.
- IDLE:
  - Grant one pending client by round-robin. A `last` bit records the previous winner; the other client wins a tie. `last` resets to B, so A wins the first tie.
  - Latch the client's address, write data, op (rd/wr) and client id → ISSUE.
- ISSUE:
  - Drive `addr_out` and `data_out` (`data_out` = 0 for reads).
  - Pulse `read_q` or `write_q` for exactly one active cycle. The RAM re-samples a held request, so the request must never be held longer.
  - Clear the timeout counter → WAIT_DN.
- WAIT_DN:
  - `addr_out` and `data_out` stay stable; `read_q` and `write_q` are 0.
  - Accept only a strobe matching the latched op with `addr_in` = latched address. On accept, capture `data_in` → RESP.
  - A mismatched or stray strobe is ignored and counted as a waiting cycle.
  - Counter increments each active cycle. On reaching `TIMEOUT`: pulse `x_err` → HALT.
- RESP: pulse `x_dn`; present captured data on `x_rdata` (reads only); update `last` → IDLE.
- HALT: pulse `rw_halt`; update `last`; clear `addr_out` and `data_out` → IDLE.
- Done strobes arriving in IDLE or ISSUE are ignored.
- A client that drops its request before `x_dn` still has its transaction completed; the pulse is still issued.
- Write data is never modified; read data is passed through at full width.

## Timing
- Reset (`rst`=0, asynchronous):
  - FSM → IDLE, counter = 0, `last` = B.
  - Every output = 0, including `rw_halt`, `busy` and both `x_rdata` buses.
  - Reset mid-transaction drops the transaction silently; no `x_dn` or `x_err` is issued.
- Latencies below count active edges only.
- Read or write against the RAM, end to end:
  - Edge 1: IDLE→ISSUE.
  - Edge 2: `read_q` or `write_q` high.
  - Edge 3: RAM enters its READ/WRITE state.
  - Edge 4: RAM done strobe.
  - Edge 5: master captures → RESP.
  - Edge 6: `x_dn` high.
  - Total: request-to-`x_dn` = 6 active edges minimum.
- Back-to-back: the next grant happens on the edge after RESP or HALT. There is one IDLE cycle between transactions.
- Timeout: `x_err` asserts `TIMEOUT`+2 active edges after the grant. `rw_halt` follows on the next active edge.
- Edges with `clk_oe`=0 freeze all state. Pulses stretch across them: a pulse stays high until the next active edge clears it.

## Test plan
- Reset, then A reads addr 0x11 from a RAM model holding 0x10 there → `read_q` is a single active cycle; `a_dn`=1 with `a_rdata`=0x10 on the 6th active edge; `b_dn` stays 0.
- A writes 0x5A to addr 3, then reads addr 3 → `write_q` is seen once; `a_dn` pulses twice; the second `a_rdata`=0x5A.
- A and B both hold reads of addr 1 and addr 2 → grant order is A, B, A, B over four transactions; each data word is routed to the correct port.
- B reads addr 0xFFFF, beyond RAM depth, with `TIMEOUT`=16 → no `read_dn`; `b_err` pulses 18 active edges after grant; `rw_halt` pulses on the next active edge; a following A read succeeds.
- In WAIT_DN, inject `read_dn` with `addr_in` ≠ the latched address, then a correct strobe → the first strobe is ignored; `x_dn` follows only the second.
- `clk_oe` toggles every other cycle during a read → latency doubles in clk edges; all pulses last exactly until the next active edge. Assert `rst`=0 mid-WAIT_DN → all outputs 0 immediately; no `x_dn` is issued.
